// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared IF/ID bundle definitions
package if_id_queue_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int AW_DEFAULT   = 32;

  // addi x0,x0,0
  localparam logic [XLEN_DEFAULT-1:0] NOP_INST_DEFAULT = 32'h00000013;

  typedef struct packed {
    logic [AW_DEFAULT-1:0]   pc;
    logic [XLEN_DEFAULT-1:0] inst;
    logic                    fault;
  } if_id_entry_t;

  function automatic if_id_entry_t if_id_bubble();
    if_id_entry_t e;
    e.pc    = '0;
    e.inst  = NOP_INST_DEFAULT;
    e.fault = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/if_id_queue_ptr.sv
// rtl/if_id_queue_ptr.sv - wrap-around pointer and occupancy controller
module if_id_queue_ptr #(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq_valid,
  input  logic          deq_ready,
  output logic          wr_en,
  output logic          rd_adv,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // full blocks enqueue regardless of a same-cycle dequeue: no ready bypass
  assign wr_en  = enq_valid && !full  && !flush;
  assign rd_adv = deq_ready && !empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry in-order fetch-to-decode queue
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter  int                   XLEN     = XLEN_DEFAULT,
  parameter  int                   AW       = AW_DEFAULT,
  parameter  int                   DEPTH    = 2,
  parameter  logic [XLEN-1:0]      NOP_INST = NOP_INST_DEFAULT,
  localparam int                   CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [AW-1:0]   enq_pc,
  input  logic [XLEN-1:0] enq_inst,
  input  logic            enq_fault,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [AW-1:0]   deq_pc,
  output logic [XLEN-1:0] deq_inst,
  output logic            deq_fault,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic          wr_en;
  logic          rd_adv;
  logic          full;
  logic          empty;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  if_id_queue_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .deq_ready (deq_ready),
    .wr_en     (wr_en),
    .rd_adv    (rd_adv),
    .full      (full),
    .empty     (empty),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  // storage is intentionally unreset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{pc: enq_pc, inst: enq_inst, fault: enq_fault};
    end
  end

  assign head      = mem[rd_ptr];
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign deq_pc    = empty ? '0       : head.pc;
  assign deq_inst  = empty ? NOP_INST : head.inst;
  assign deq_fault = empty ? 1'b0     : head.fault;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue at DEPTH 2 and 4
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = '0;
  logic [31:0] enq_inst = '0;
  logic        enq_fault = 1'b0;
  logic        deq_ready = 1'b0;

  logic        a_enq_ready, a_deq_valid, a_deq_fault;
  logic [31:0] a_deq_pc, a_deq_inst;
  logic [1:0]  a_count;
  logic        b_enq_ready, b_deq_valid, b_deq_fault;
  logic [31:0] b_deq_pc, b_deq_inst;
  logic [2:0]  b_count;

  ent_t sba[$];
  ent_t sbb[$];
  int   ma = 0;
  int   mb = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(a_enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_fault(enq_fault),
    .deq_valid(a_deq_valid), .deq_ready(deq_ready),
    .deq_pc(a_deq_pc), .deq_inst(a_deq_inst), .deq_fault(a_deq_fault),
    .count(a_count)
  );

  if_id_queue #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(b_enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_fault(enq_fault),
    .deq_valid(b_deq_valid), .deq_ready(deq_ready),
    .deq_pc(b_deq_pc), .deq_inst(b_deq_inst), .deq_fault(b_deq_fault),
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic f, input logic rdy);
    enq_valid = v;
    enq_pc    = pc;
    enq_inst  = inst;
    enq_fault = f;
    deq_ready = rdy;
  endtask

  // Check head/flags against both models, advance the models, then clock once.
  task automatic tick();
    ent_t e;
    bit   ea, da, eb, db;
    e  = '{pc: enq_pc, inst: enq_inst, fault: enq_fault};
    ea = enq_valid && (ma != 2) && !flush;
    da = deq_ready && (ma != 0) && !flush;
    eb = enq_valid && (mb != 4) && !flush;
    db = deq_ready && (mb != 0) && !flush;

    chk("a_enq_ready", 65'(a_enq_ready), 65'(ma != 2));
    chk("a_deq_valid", 65'(a_deq_valid), 65'(ma != 0));
    if (ma == 0) chk("a_bubble", {a_deq_pc, a_deq_inst, a_deq_fault}, {32'h0, 32'h00000013, 1'b0});
    else         chk("a_head",   {a_deq_pc, a_deq_inst, a_deq_fault}, sba[0]);
    chk("b_enq_ready", 65'(b_enq_ready), 65'(mb != 4));
    chk("b_deq_valid", 65'(b_deq_valid), 65'(mb != 0));
    if (mb == 0) chk("b_bubble", {b_deq_pc, b_deq_inst, b_deq_fault}, {32'h0, 32'h00000013, 1'b0});
    else         chk("b_head",   {b_deq_pc, b_deq_inst, b_deq_fault}, sbb[0]);

    if (flush) begin
      sba.delete(); ma = 0;
      sbb.delete(); mb = 0;
    end else begin
      if (da) begin void'(sba.pop_front()); ma--; end
      if (ea) begin sba.push_back(e); ma++; end
      if (db) begin void'(sbb.pop_front()); mb--; end
      if (eb) begin sbb.push_back(e); mb++; end
    end

    @(posedge clk);
    #1;
    chk("a_count", 65'(a_count), 65'(ma));
    chk("b_count", 65'(b_count), 65'(mb));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state and idle
    tick();
    tick();

    // single push, visible next cycle, then bubble returns
    drive(1, 32'h100, 32'h00500093, 0, 1);
    tick();
    drive(0, 32'h0, 32'h0, 0, 1);
    chk("push_pc",   65'(a_deq_pc),   65'(32'h100));
    chk("push_inst", 65'(a_deq_inst), 65'(32'h00500093));
    tick();
    tick();

    // stall fill; third push refused by the DEPTH=2 queue
    drive(1, 32'h100, 32'h00000113, 0, 0); tick();
    drive(1, 32'h104, 32'h00000193, 0, 0); tick();
    chk("full_ready", 65'(a_enq_ready), 65'(1'b0));
    drive(1, 32'h108, 32'h00000213, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 1);
    repeat (4) tick();

    // streaming at count 1
    drive(1, 32'h200, 32'h00100093, 0, 1); tick();
    drive(1, 32'h204, 32'h00200093, 0, 1); tick();
    drive(1, 32'h208, 32'h00300093, 0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 1);
    repeat (4) tick();

    // flush with a simultaneous enqueue
    drive(1, 32'h2f0, 32'h00400093, 0, 0); tick();
    drive(1, 32'h2f4, 32'h00500093, 0, 0); tick();
    drive(1, 32'h300, 32'h00600093, 0, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 1);
    chk("flush_inst", 65'(a_deq_inst), 65'(32'h00000013));
    tick();
    tick();

    // asynchronous reset between edges
    drive(1, 32'h500, 32'h00700093, 0, 0); tick();
    drive(1, 32'h504, 32'h00800093, 0, 0); tick();
    chk("pre_reset_cnt", 65'(a_count), 65'(2));
    drive(0, 32'h0, 32'h0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_cnt_a", 65'(a_count), 65'(0));
    chk("async_rst_cnt_b", 65'(b_count), 65'(0));
    chk("async_rst_inst",  65'(a_deq_inst), 65'(32'h00000013));
    sba.delete(); ma = 0;
    sbb.delete(); mb = 0;
    #1;
    reset = 1'b0;
    drive(1, 32'h600, 32'h00900093, 0, 1);
    tick();
    chk("post_reset_enq", 65'(a_count), 65'(1));
    drive(0, 32'h0, 32'h0, 0, 1);
    repeat (2) tick();

    // wrap-around with a faulting entry mid-stream
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc;
      pc = 32'h3e0 + 32'(4 * i);
      drive(1, pc, $urandom, pc == 32'h400, i >= 3);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 1);
    repeat (8) tick();
    chk("final_cnt_a", 65'(a_count), 65'(0));
    chk("final_cnt_b", 65'(b_count), 65'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry in-order queue between instruction fetch (ROM + PC) and decode.
- Carries PC, instruction word and a fetch-fault flag per entry.
- Ready/valid handshake on both sides. Decode stall is expressed as deq_ready low.
- Single-cycle flush from branch/hazard logic. When empty, the queue presents a NOP bubble to decode.

Parameters:
- XLEN, 32, instruction word width.
- AW, 32, PC width.
- DEPTH, 2, number of entries; power of two, at least 2.
- NOP_INST, 32'h00000013, bubble instruction driven when empty (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears queue.
- flush  input  1  synchronous discard of all entries (branch taken / redirect).
- enq_valid  input  1  fetch presents an entry.
- enq_ready  output  1  queue can accept an entry.
- enq_pc  input  AW  PC of fetched instruction.
- enq_inst  input  XLEN  fetched instruction from ROM.
- enq_fault  input  1  fetch access fault for this entry.
- deq_valid  output  1  head entry valid for decode.
- deq_ready  input  1  decode consumes the head (low = stall).
- deq_pc  output  AW  head PC.
- deq_inst  output  XLEN  head instruction, or NOP_INST when empty.
- deq_fault  output  1  head fault flag, 0 when empty.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: DEPTH-entry register array {pc, inst, fault}. Read pointer rd_ptr and write pointer wr_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in count.
- Reset (async, active-high): rd_ptr=0, wr_ptr=0, count=0. Outputs immediately become deq_valid=0, deq_inst=NOP_INST, deq_pc=0, deq_fault=0, enq_ready=1. Array contents are don't-care and are not reset.
- enq_ready = (count != DEPTH). It depends only on state, with no combinational path from deq_ready; when full, an enqueue is refused even if a dequeue happens in the same cycle.
- deq_valid = (count != 0).
- Head fields come combinationally from array[rd_ptr] when deq_valid, otherwise the bubble values.
- Enqueue fire: enq_valid && enq_ready. At the clock edge, write the entry to array[wr_ptr] and increment wr_ptr.
- Dequeue fire: deq_valid && deq_ready. At the clock edge, increment rd_ptr.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.
- Latency: an entry enqueued at edge N is visible on deq_* after edge N (deq_valid high in cycle N+1); minimum one cycle, no fall-through.
- Simultaneous enqueue and dequeue at count=1: the head advances to the new entry, count stays 1, and deq_valid stays high.
- Flush has priority over everything. At the edge: pointers=0, count=0. Any enqueue or dequeue in that cycle is discarded. The next cycle shows the bubble with enq_ready=1.
- Reset asserted mid-operation: state clears immediately without waiting for clk; the first enqueue after deassertion is accepted on the next edge.
- enq_* values presented when enq_ready=0 are ignored. Fetch must hold its PC (locker semantics).
- Stall (deq_ready=0) holds all deq_* outputs stable while the queue keeps filling up to DEPTH.

Decomposition:
- Shared package/define file holds NOP_INST, default XLEN/AW, and the typedef/struct for the queue entry {pc, inst, fault}, so ID and later stages reuse the same bundle.
- One natural sub-module, if_id_queue_ptr: wrap-around pointer/count controller producing wr_en, rd_adv, full and empty. The data array stays in the top module.

Test Plan:
- Reset then idle: deq_valid=0, deq_inst=32'h00000013, count=0, enq_ready=1. Assert reset mid-clock with count=2 → count=0 immediately.
- Push pc=0x100/inst=0x00500093 with deq_ready=1 → next cycle deq_pc=0x100, deq_inst=0x00500093. The one after, the bubble returns.
- Stall fill, DEPTH=2: deq_ready=0, push pc 0x100 and 0x104 → count=2, enq_ready=0. A third push of 0x108 is ignored. Release stall → decode sees 0x100 then 0x104, never 0x108.
- Streaming with both fires every cycle at count=1: PCs 0x200, 0x204, 0x208 flow in order, count stays 1, and deq_valid never drops.
- Flush with count=2 and a simultaneous enqueue of 0x300 → next cycle count=0, bubble on deq_inst, and 0x300 is never dequeued.
- Wrap-around and fault, DEPTH=4: push/pop 10 entries with pointers wrapping twice → order is preserved. An entry with enq_fault=1 at pc 0x400 produces deq_fault=1 only while it is the head.
